// File: rtl/wait_timer.sv
// Programmable-limit wait timer with clock prescaler and one-shot, periodic and free-run modes.
// Expiry is flagged by a registered one-cycle pulse that lines up with the count value that caused it.
module wait_timer #(
  parameter int WIDTH = 14,
  parameter int PW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  input  logic [PW-1:0]    presc,
  output logic [WIDTH-1:0] count,
  output logic             expired,
  output logic             done,
  output logic             busy,
  output logic             cfg_err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [1:0]       mode_q, mode_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             exp_q, exp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] lim_dec;

  assign cnt_inc = count_q + 1'b1;
  assign lim_dec = lim_q - 1'b1;

  // State register: every piece of timer state lives here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      psc_q   <= '0;
      lim_q   <= '0;
      mode_q  <= '0;
      presc_q <= '0;
      exp_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      psc_q   <= psc_d;
      lim_q   <= lim_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
    end
  end

  // Next state. Control inputs are single-cycle requests with no handshake; on any edge the
  // winner is clr > start > stop > pause > prescaler tick, and the losers are simply dropped.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    psc_d   = psc_q;
    lim_d   = lim_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    exp_d   = 1'b0;
    err_d   = err_q;
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
      psc_d   = '0;
      lim_d   = '0;
      mode_d  = '0;
      presc_d = '0;
      err_d   = 1'b0;
    end else if (start) begin
      if (limit == '0 && mode != 2'd2) begin
        // A zero limit can never be reached by a counting mode: refuse and keep the old count.
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        lim_d   = limit;
        mode_d  = mode;
        presc_d = presc;
        count_d = '0;
        psc_d   = '0;
        err_d   = 1'b0;
        state_d = RUN;
      end
    end else if (stop && state_q == RUN) begin
      state_d = IDLE;
    end else if (state_q == RUN && !pause) begin
      if (psc_q == presc_q) begin
        psc_d = '0;
        case (mode_q)
          2'd1: begin
            if (count_q == lim_dec) begin
              count_d = '0;
              exp_d   = 1'b1;
            end else begin
              count_d = cnt_inc;
            end
          end
          2'd2: begin
            count_d = cnt_inc;
            exp_d   = (count_q == {WIDTH{1'b1}});
          end
          default: begin
            count_d = cnt_inc;
            if (cnt_inc == lim_q) begin
              state_d = DONE;
              exp_d   = 1'b1;
            end
          end
        endcase
      end else begin
        psc_d = psc_q + 1'b1;
      end
    end
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    count     = count_q;
    expired   = exp_q;
    cfg_err   = err_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_wait_timer.sv
// Directed bench for wait_timer (WIDTH=4 so the free-run wrap is reachable quickly).
// Expected outputs are queued as each step is driven and compared one cycle later.
module tb_wait_timer;
  localparam int W  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst, clr, start, stop, pause;
  logic [W-1:0]  limit;
  logic [1:0]    mode;
  logic [PW-1:0] presc;
  logic [W-1:0]  count;
  logic          expired, done, busy, cfg_err;
  logic [1:0]    state_dbg;

  logic [W+3:0]  exp_q[$];
  int            nvec  = 0;
  int            nfail = 0;

  wait_timer #(.WIDTH(W), .PW(PW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .stop(stop), .pause(pause),
    .limit(limit), .mode(mode), .presc(presc),
    .count(count), .expired(expired), .done(done), .busy(busy), .cfg_err(cfg_err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Queue the expectation for the coming edge, let the edge happen, then compare mid-cycle.
  task automatic chk(input string tag, input logic [W-1:0] c, input logic e, input logic d,
                     input logic b, input logic r);
    logic [W+3:0] want, got;
    exp_q.push_back({c, e, d, b, r});
    @(posedge clk);
    @(negedge clk);
    want = exp_q.pop_front();
    got  = {count, expired, done, busy, cfg_err};
    nvec++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: got count=%0d expired=%b done=%b busy=%b cfg_err=%b, expected count=%0d expired=%b done=%b busy=%b cfg_err=%b",
             tag, got[W+3:4], got[3], got[2], got[1], got[0],
             want[W+3:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; start = 1'b1; stop = 1'b0; pause = 1'b0;
    limit = '0; mode = 2'd0; presc = '0;
    chk("rst_with_start", 0, 0, 0, 0, 0);
    rst = 1'b0; start = 1'b0;
    chk("idle", 0, 0, 0, 0, 0);

    // One-shot L=5 P=0
    limit = 4'd5; mode = 2'd0; presc = 8'd0; start = 1'b1;
    chk("os_start", 0, 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 1; k < 5; k++) chk("os_run", W'(k), 0, 0, 1, 0);
    chk("os_expire", 5, 1, 1, 0, 0);
    stop = 1'b1;
    chk("stop_in_done", 5, 0, 1, 0, 0);
    stop = 1'b0;
    repeat (10) chk("os_hold", 5, 0, 1, 0, 0);

    // Periodic L=3 P=2: a tick every 3 cycles, expiry every 9
    limit = 4'd3; mode = 2'd1; presc = 8'd2; start = 1'b1;
    chk("per_start", 0, 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 27; k++) chk("per_run", W'((k / 3) % 3), (k % 9 == 0), 0, 1, 0);

    // One-shot L=10 with a 4-cycle pause at count 3
    limit = 4'd10; mode = 2'd0; presc = 8'd0; start = 1'b1;
    chk("ps_start", 0, 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) chk("ps_run", W'(k), 0, 0, 1, 0);
    pause = 1'b1;
    repeat (4) chk("ps_paused", 3, 0, 0, 1, 0);
    pause = 1'b0;
    for (int k = 4; k <= 9; k++) chk("ps_resume", W'(k), 0, 0, 1, 0);
    chk("ps_expire", 10, 1, 1, 0, 0);

    // Stop at count 6
    start = 1'b1;
    chk("st_start", 0, 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 6; k++) chk("st_run", W'(k), 0, 0, 1, 0);
    stop = 1'b1;
    chk("stop_run", 6, 0, 0, 0, 0);
    stop = 1'b0;
    repeat (3) chk("stop_idle", 6, 0, 0, 0, 0);

    // Free-run with L=0: legal, wraps every 16 ticks
    limit = 4'd0; mode = 2'd2; start = 1'b1;
    chk("fr_start", 0, 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 33; k++) chk("fr_run", W'(k % 16), (k % 16 == 0), 0, 1, 0);

    // Zero limit in counting modes: error, IDLE, count left at 1
    limit = 4'd0; mode = 2'd0; start = 1'b1;
    chk("err_mode0", 1, 0, 0, 0, 1);
    start = 1'b0;
    chk("err_sticky", 1, 0, 0, 0, 1);
    mode = 2'd3; start = 1'b1;
    chk("err_mode3", 1, 0, 0, 0, 1);
    start = 1'b0;

    // Good start clears the error; restart on the would-be expiry edge suppresses the pulse
    limit = 4'd4; mode = 2'd0; start = 1'b1;
    chk("ok_start", 0, 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) chk("rs_run", W'(k), 0, 0, 1, 0);
    start = 1'b1;
    chk("restart", 0, 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) chk("rs_run2", W'(k), 0, 0, 1, 0);
    chk("rs_expire", 4, 1, 1, 0, 0);

    // Largest legal limit
    limit = 4'd15; start = 1'b1;
    chk("max_start", 0, 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 14; k++) chk("max_run", W'(k), 0, 0, 1, 0);
    chk("max_expire", 15, 1, 1, 0, 0);

    // clr mid-run at count 7
    start = 1'b1;
    chk("clr_setup", 0, 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 7; k++) chk("clr_run", W'(k), 0, 0, 1, 0);
    clr = 1'b1;
    chk("clr_run_stop", 0, 0, 0, 0, 0);
    clr = 1'b0;

    // clr beats start and also drops a sticky error
    limit = 4'd0; mode = 2'd1; start = 1'b1;
    chk("err_mode1", 0, 0, 0, 0, 1);
    limit = 4'd4; clr = 1'b1;
    chk("clr_vs_start", 0, 0, 0, 0, 0);
    clr = 1'b0; start = 1'b0;
    chk("clr_idle", 0, 0, 0, 0, 0);

    // rst with start held
    mode = 2'd0; start = 1'b1;
    chk("rst_setup", 0, 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 2; k++) chk("rst_run", W'(k), 0, 0, 1, 0);
    rst = 1'b1; start = 1'b1;
    chk("rst_mid_run", 0, 0, 0, 0, 0);
    rst = 1'b0; start = 1'b0;
    chk("rst_idle", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/wait_timer.md
Name: wait_timer

Overview:
- Parametrised successor to the UART path's simple wait counter.
- Programmable-limit timer with a clock prescaler and three modes: one-shot, periodic (auto-reload) and free-run.
- Flags expiry with a one-cycle pulse and a sticky done level.
- Used by the UART TX/RX control FSMs and the FIFO flush logic for bit-time waits, inter-frame gaps and timeouts.

Parameters:
- WIDTH, 14, width of count and limit.
- PW, 8, width of the prescale value.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear: count, prescaler and flags to 0; state to IDLE.
- start  in  1  pulse: latch limit/mode/presc; restart counting from 0.
- stop  in  1  abort: go to IDLE and hold count.
- pause  in  1  level: freeze prescaler and count while RUN.
- limit  in  WIDTH  terminal value L; sampled only on start.
- mode  in  2  0 one-shot, 1 periodic, 2 free-run, 3 treated as one-shot; sampled on start.
- presc  in  PW  prescale P; one count tick every P+1 clk cycles; sampled on start.
- count  out  WIDTH  current count.
- expired  out  1  one-cycle pulse on expiry or wrap.
- done  out  1  high in the DONE state.
- busy  out  1  high in RUN, including while paused.
- cfg_err  out  1  sticky flag: start issued with L=0 in mode 0, 1 or 3.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset and clr values: count=0, prescaler=0, expired=0, done=0, busy=0, cfg_err=0, state=IDLE, latched limit/mode/presc=0.
- States: IDLE, RUN, DONE.
- Priority per edge: rst > clr > start > stop > pause > tick.
- start, in any state:
  - Latch L, mode, P; set count=0, prescaler=0, cfg_err=0; go to RUN.
  - Exception: if L=0 and mode≠2, set cfg_err=1, go to IDLE, leave count unchanged.
- stop: from RUN to IDLE; count holds its value; done=0; no expired pulse.
- stop in IDLE or DONE: ignored.
- pause=1 in RUN: prescaler and count hold; busy stays 1; no tick.
- Tick:
  - In RUN with pause=0, the prescaler counts 0..P.
  - On the edge where prescaler==P, the prescaler returns to 0 and a tick occurs.
  - P=0 gives a tick every cycle.
- On tick, by latched mode:
  - One-shot (0/3): count+1. When the new value equals L: state goes to DONE, count holds L, expired=1 for one cycle, done=1 until start/clr/rst.
  - Periodic (1): count runs 0..L-1. On a tick with count==L-1, count goes to 0, expired=1 for one cycle, state stays RUN.
  - Free-run (2): L is ignored. Count increments modulo 2^WIDTH; expired=1 for one cycle on the 2^WIDTH-1 → 0 wrap.
- Timing:
  - expired is registered and coincident with the count value that caused it.
  - One-shot expiry occurs L·(P+1) cycles after the start edge.
  - Periodic expiry then repeats every L·(P+1) cycles.
- Restart: start while in RUN restarts from 0 with new config. If that edge would also have ticked to expiry, start wins: no expired pulse.
- Pause and tick on the same edge: pause wins; the tick is deferred until pause=0.
- Arithmetic: all count compares are unsigned WIDTH-bit. L=2^WIDTH-1 is legal.
- Outputs: busy=(state==RUN); done=(state==DONE).

Test Plan:
- One-shot: rst, then start with L=5, P=0, mode=0 → count 0,1,2,3,4,5 on successive cycles; expired high exactly one cycle with count=5, 5 cycles after start; done=1 and count held at 5 for 10+ cycles.
- Periodic with prescale: start with L=3, P=2, mode=1 → count increments every 3 cycles (0,1,2,0…); expired pulses every 9 cycles; busy stays 1; never DONE.
- Pause and stop: one-shot with L=10, P=0; pause high for 4 cycles at count=3 → count holds 3; expiry delayed by 4 cycles. Separately, stop at count=6 → IDLE, count stays 6, no expired.
- Free-run wrap (WIDTH=4): start mode=2, L=0 → no cfg_err; count 0..15 then 0; expired exactly at the wrap, every 16 cycles.
- Error and restart: start with L=0, mode=0 → cfg_err=1, busy=0. Next start with L=4 → cfg_err=0. Start re-issued at count=3 (L=4) → count to 0, no expired pulse.
- Clear/reset mid-run: clr asserted during RUN at count=7 → next cycle all outputs 0, IDLE. clr and start on the same edge → IDLE (clr wins). rst with start high → all outputs 0.
